// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch_state_e : fetch FSM states (FETCH / ISSUE / ERROR)
//   - instruction field bit positions (Cond, Op, Funct, Rd, sh)
//   - INSTR_BYTES   : size of one instruction word in bytes
//   - fetch_dbg_t   : debug snapshot exported by the fetch unit
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_e;

  // Instruction field bit positions
  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_LSB = 20;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 12;
  localparam int SH_MSB    = 6;
  localparam int SH_LSB    = 5;

  localparam logic [31:0] INSTR_BYTES   = 32'd4;
  // Branch targets are forced onto an instruction boundary.
  localparam logic [31:0] PC_ALIGN_MASK = ~(INSTR_BYTES - 32'd1);

  // Debug snapshot: FSM state, fetch wait counter, sequential next PC.
  typedef struct packed {
    fetch_state_e state;
    logic [7:0]   wait_cnt;
    logic [31:0]  seq_pc;
  } fetch_dbg_t;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// ---------------------------------------------------------------------------
// pc_register
// Program counter register with its next-PC mux.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset, loads RESET_PC
//   en      : update PC this cycle (instruction consumed)
//   PCSrc   : 1 = take branch target, 0 = sequential PC+4
//   Result  : branch target (low two bits are dropped)
//   PC      : current program counter
//   PCPlus4 : PC + 4 (mod 2^32)
//   PCPlus8 : PC + 8 (mod 2^32)
// ---------------------------------------------------------------------------
module pc_register
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] PCPlus8
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // 32-bit adds wrap naturally modulo 2^32.
  assign PCPlus4   = r_pc + INSTR_BYTES;
  assign PCPlus8   = PCPlus4 + INSTR_BYTES;
  assign w_pc_next = PCSrc ? (Result & PC_ALIGN_MASK) : PCPlus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (en) begin
      r_pc <= w_pc_next;
    end
  end

  assign PC = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetches one instruction at a time from instruction memory, holds it in an
// instruction register for the control unit, and advances the PC once the
// instruction is consumed. A fetch that never completes within TIMEOUT
// cycles parks the unit in ERROR until reset.
//
// Ports:
//   clk, rst              : clock / asynchronous active-low reset
//   imem_req, imem_addr   : instruction memory read request and address (=PC)
//   imem_rdata, imem_ack  : read data and completion strobe
//   stall_in              : downstream hold, issued instruction not consumed
//   PCSrc, Result         : branch taken flag and branch target
//   Instr, instr_valid    : registered instruction and its valid flag
//   Cond/Op/Funct/Rd/sh   : decoded fields of Instr
//   PC, PCPlus8           : address of issued instruction and PC+8
//   retired_count         : number of consumed instructions (wraps)
//   fetch_err             : sticky fetch timeout flag
//   dbg                   : FSM state, wait counter and sequential next PC
//
// Memory handshake: in FETCH, imem_req is held high with imem_addr=PC and
// neither changes until a cycle in which imem_ack=1; that cycle transfers
// imem_rdata. An ack may arrive in the very first request cycle. imem_ack
// in any other state carries no meaning and is ignored.
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall_in,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rd,
  output logic [1:0]  sh,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic [31:0] retired_count,
  output logic        fetch_err,
  output fetch_dbg_t  dbg
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic [7:0]  r_wait;
  logic        r_err;

  logic [7:0]  w_wait_next;
  logic        w_req;
  logic        w_valid;
  logic        w_load_instr;
  logic        w_retire;
  logic        w_wait_inc;
  logic        w_wait_clr;
  logic        w_err_set;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;

  assign w_wait_next = r_wait + 8'd1;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and control
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_valid      = 1'b0;
    w_load_instr = 1'b0;
    w_retire     = 1'b0;
    w_wait_inc   = 1'b0;
    w_wait_clr   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          // An ack in the timeout cycle still counts: it is checked first.
          w_load_instr = 1'b1;
          w_state_next = ST_ISSUE;
        end else begin
          w_wait_inc = 1'b1;
          if (w_wait_next == TIMEOUT) begin
            w_err_set    = 1'b1;
            w_state_next = ST_ERROR;
          end
        end
      end
      ST_ISSUE: begin
        w_valid = 1'b1;
        if (!stall_in) begin
          w_retire     = 1'b1;
          w_wait_clr   = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_ERROR: begin
        w_state_next = ST_ERROR;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Instruction register, counters and error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr   <= 32'd0;
      r_retired <= 32'd0;
      r_wait    <= 8'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_load_instr) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_retired <= r_retired + 32'd1;
      end
      if (w_wait_clr) begin
        r_wait <= 8'd0;
      end else if (w_wait_inc) begin
        r_wait <= w_wait_next;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Program counter (advances only on the consuming cycle)
  // ---------------------------------------------------------------------
  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst     (rst),
    .en      (w_retire),
    .PCSrc   (PCSrc),
    .Result  (Result),
    .PC      (w_pc),
    .PCPlus4 (w_pc_plus4),
    .PCPlus8 (w_pc_plus8)
  );

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The state register already reads FETCH during reset, so the request
  // is gated with rst to keep it low until reset is released.
  assign imem_req      = w_req & rst;
  assign imem_addr     = w_pc;
  assign instr_valid   = w_valid;
  assign Instr         = r_instr;
  assign Cond          = r_instr[COND_MSB:COND_LSB];
  assign Op            = r_instr[OP_MSB:OP_LSB];
  assign Funct         = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign Rd            = r_instr[RD_MSB:RD_LSB];
  assign sh            = r_instr[SH_MSB:SH_LSB];
  assign PC            = w_pc;
  assign PCPlus8       = w_pc_plus8;
  assign retired_count = r_retired;
  assign fetch_err     = r_err;

  assign dbg.state     = r_state;
  assign dbg.wait_cnt  = r_wait;
  assign dbg.seq_pc    = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Transaction-level bench for instr_fetch_unit. Each instruction is one
// fetch (N wait cycles then an ack) followed by one issue (M stall cycles
// then a consume). The reference model keeps only the expected PC and the
// retired count and updates them with plain arithmetic per instruction.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [7:0]  TB_TIMEOUT  = 8'd4;

  // ---------------- clock / reset / DUT signals ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        stall_in;
  logic        PCSrc;
  logic [31:0] Result;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [1:0]  sh;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic [31:0] retired_count;
  logic        fetch_err;
  fetch_dbg_t  dbg;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (TB_RESET_PC),
    .TIMEOUT  (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ack      (imem_ack),
    .stall_in      (stall_in),
    .PCSrc         (PCSrc),
    .Result        (Result),
    .Instr         (Instr),
    .instr_valid   (instr_valid),
    .Cond          (Cond),
    .Op            (Op),
    .Funct         (Funct),
    .Rd            (Rd),
    .sh            (sh),
    .PC            (PC),
    .PCPlus8       (PCPlus8),
    .retired_count (retired_count),
    .fetch_err     (fetch_err),
    .dbg           (dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst        = 1'b0;
    imem_ack   = 1'b0;
    stall_in   = 1'b0;
    PCSrc      = 1'b0;
    Result     = 32'd0;
    imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_req",     32'(imem_req), 32'd0);
    check_eq("rst_valid",   32'(instr_valid), 32'd0);
    check_eq("rst_pc",      PC, TB_RESET_PC);
    check_eq("rst_retired", retired_count, 32'd0);
    check_eq("rst_err",     32'(fetch_err), 32'd0);
    check_eq("rst_instr",   Instr, 32'd0);
    rst   = 1'b1;
    m_pc  = TB_RESET_PC;
    m_ret = 32'd0;
  endtask

  // waits no-ack cycles, then an ack carrying word.
  task automatic fetch_instr(input int waits, input logic [31:0] word);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check_eq("fetch_req",     32'(imem_req), 32'd1);
      check_eq("fetch_addr",    imem_addr, m_pc);
      check_eq("fetch_valid",   32'(instr_valid), 32'd0);
      check_eq("fetch_retired", retired_count, m_ret);
      check_eq("fetch_err",     32'(fetch_err), 32'd0);
      imem_ack   = (i == waits);
      imem_rdata = (i == waits) ? word : $urandom();
      stall_in   = 1'($urandom_range(0, 1));
      PCSrc      = 1'($urandom_range(0, 1));
      Result     = $urandom();
    end
  endtask

  // stalls hold cycles with noise on the branch inputs, then a consume.
  task automatic issue_instr(input int stalls, input logic br,
                             input logic [31:0] tgt, input logic [31:0] word);
    for (int i = 0; i <= stalls; i++) begin
      @(negedge clk);
      check_eq("issue_valid",   32'(instr_valid), 32'd1);
      check_eq("issue_req",     32'(imem_req), 32'd0);
      check_eq("issue_instr",   Instr, word);
      check_eq("issue_cond",    32'(Cond),  32'(word[31:28]));
      check_eq("issue_op",      32'(Op),    32'(word[27:26]));
      check_eq("issue_funct",   32'(Funct), 32'(word[25:20]));
      check_eq("issue_rd",      32'(Rd),    32'(word[15:12]));
      check_eq("issue_sh",      32'(sh),    32'(word[6:5]));
      check_eq("issue_pc",      PC, m_pc);
      check_eq("issue_pc8",     PCPlus8, m_pc + 32'd8);
      check_eq("issue_seq_pc",  dbg.seq_pc, m_pc + 32'd4);
      check_eq("issue_retired", retired_count, m_ret);
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom();
      stall_in   = (i < stalls);
      PCSrc      = (i < stalls) ? 1'($urandom_range(0, 1)) : br;
      Result     = (i < stalls) ? $urandom() : tgt;
    end
    m_pc  = br ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic run_instr(input int waits, input int stalls, input logic br,
                           input logic [31:0] tgt, input logic [31:0] word);
    fetch_instr(waits, word);
    issue_instr(stalls, br, tgt, word);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    do_reset();

    // Zero-wait fetch of a known word, consumed immediately.
    run_instr(0, 0, 1'b0, 32'd0, 32'hE281_1001);
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("dir_cond",    32'(Cond),  32'hE);
    check_eq("dir_op",      32'(Op),    32'h0);
    check_eq("dir_funct",   32'(Funct), 32'h28);
    check_eq("dir_rd",      32'(Rd),    32'h1);
    check_eq("dir_sh",      32'(sh),    32'h0);
    check_eq("dir_pc4",     PC, 32'h4);
    check_eq("dir_retired", retired_count, 32'd1);

    // Five stall cycles then a taken branch to an unaligned target.
    w = $urandom();
    run_instr(1, 5, 1'b1, 32'h0000_0103, w);
    // Ack on the last allowed wait cycle; branch to the top of memory.
    w = $urandom();
    run_instr(3, 0, 1'b1, 32'hFFFF_FFFC, w);
    // Sequential step across the 2^32 wrap.
    w = $urandom();
    run_instr(0, 2, 1'b0, 32'd0, w);
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("wrap_pc", PC, 32'h0);
    w = $urandom();
    run_instr(2, 0, 1'b0, 32'd0, w);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      w = $urandom();
      run_instr($urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), $urandom(), w);
    end

    // Reset asserted in the middle of an ISSUE cycle.
    w = $urandom();
    fetch_instr(0, w);
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
    imem_ack = 1'b0;
    stall_in = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_valid",   32'(instr_valid), 32'd0);
    check_eq("async_rst_pc",      PC, TB_RESET_PC);
    check_eq("async_rst_retired", retired_count, 32'd0);
    check_eq("async_rst_req",     32'(imem_req), 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    m_pc  = TB_RESET_PC;
    m_ret = 32'd0;
    w = $urandom();
    run_instr(1, 1, 1'b0, 32'd0, w);
    w = $urandom();
    run_instr(0, 0, 1'b1, 32'h0000_2000, w);

    // Fetch that never completes.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("to_req",  32'(imem_req), 32'd1);
      check_eq("to_err0", 32'(fetch_err), 32'd0);
      imem_ack   = 1'b0;
      imem_rdata = $urandom();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("err_flag",  32'(fetch_err), 32'd1);
      check_eq("err_req",   32'(imem_req), 32'd0);
      check_eq("err_valid", 32'(instr_valid), 32'd0);
      check_eq("err_pc",    PC, m_pc);
      imem_ack = 1'b1;
      stall_in = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 8'd255; maximum wait cycles for imem_ack before a fetch error.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  fetch address; equals PC.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-008 imem_ack  input  1  read completion strobe.
REQ-009 stall_in  input  1  downstream hold; the issued instruction is not consumed this cycle.
REQ-010 PCSrc  input  1  branch taken, from conditional logic.
REQ-011 Result  input  32  branch target, from the result bus.
REQ-012 Instr  output  32  registered instruction word.
REQ-013 instr_valid  output  1  Instr and its fields are valid for the control unit.
REQ-014 Cond, Op, Funct, Rd, sh  output  4/2/6/4/2  Instr[31:28], [27:26], [25:20], [15:12], [6:5].
REQ-015 PC  output  32  address of the issued instruction.
REQ-016 PCPlus8  output  32  PC+8, for R15 reads.
REQ-017 retired_count  output  32  count of consumed instructions.
REQ-018 fetch_err  output  1  sticky imem timeout flag.

Function
REQ-019 FSM states: FETCH, ISSUE, ERROR.
REQ-020 FETCH: imem_req=1 and imem_addr=PC, held stable until ack; imem_ack=1 latches imem_rdata into Instr and moves to ISSUE; an ack in the same cycle as the first req is legal.
REQ-021 ISSUE: instr_valid=1 and imem_req=0; with stall_in=1, state, PC, and Instr hold.
REQ-022 ISSUE with stall_in=0 consumes the instruction: PC <= PCSrc ? {Result[31:2],2'b00} : PC+4, retired_count increments, next state is FETCH.
REQ-023 PCSrc and Result are sampled only on the consuming cycle; otherwise they are ignored.
REQ-024 Minimum throughput is 2 cycles per instruction (zero-wait ack), with 1 additional cycle per wait state.
REQ-025 PC+4 and PC+8 are computed modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000); retired_count wraps at 2^32.
REQ-026 A wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT with no ack, fetch_err is set and the FSM enters ERROR.
REQ-028 An ack on the same cycle the counter reaches TIMEOUT wins; no error is raised.
REQ-029 ERROR: imem_req=0 and instr_valid=0; the unit stays in ERROR until reset.
REQ-030 imem_ack outside FETCH is ignored.
REQ-031 instr_valid is never asserted in FETCH or ERROR.

Reset
REQ-032 Reset is asserted asynchronously and deasserted synchronously to clk by the system.
REQ-033 Reset values: state=FETCH, PC=RESET_PC, Instr=0, instr_valid=0, retired_count=0, wait counter=0, fetch_err=0.
REQ-034 imem_req is 0 while reset is asserted and 1 from the first cycle after deassertion.
REQ-035 Reset asserted mid-fetch or mid-issue discards the in-flight instruction immediately; a late ack after reset deassertion is ignored unless the FSM is in FETCH.

Structure
REQ-036 The shared core package holds the fetch state enum (FETCH/ISSUE/ERROR), the instruction field bit-position constants, and the INSTR_BYTES=4 constant.
REQ-037 The PC register and next-PC mux form one sub-module, pc_register (inputs: clk, rst, en, PCSrc, Result; outputs: PC, PCPlus4, PCPlus8).
REQ-038 The FSM, instruction register, and counters reside in instr_fetch_unit.

Verification
REQ-039 Reset release, zero-wait ack, rdata=0xE2811001, stall_in=0 -> Cond=0xE, Op=00, Funct=0x28, Rd=1, sh=00; PC=0 then 4; retired_count=1 after 2 cycles.
REQ-040 Ack delayed 3 cycles -> imem_addr constant for 4 cycles; instr_valid rises the cycle after ack.
REQ-041 ISSUE with stall_in=1 for 5 cycles, then PCSrc=1, Result=0x0000_0103 -> PC held at the old value for 5 cycles, then PC=0x0000_0100.
REQ-042 PC=0xFFFF_FFFC, consume with PCSrc=0 -> PC=0x0000_0000; PCPlus8 for the old PC = 0x0000_0004.
REQ-043 TIMEOUT=4, no ack -> fetch_err=1 after 4 wait cycles, imem_req=0, FSM stuck in ERROR; ack on the 4th cycle -> no error.
REQ-044 Reset asserted while in ISSUE -> instr_valid=0 asynchronously; PC=RESET_PC; retired_count=0.
